nap_timer_ctrl: RTL and testbench
=================================

NAP_TIMER_CTRL -- requirements
Module: nap_timer_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000: clock cycles per one-second tick.
REQ-002 Parameter RING_ON_SEC, default 1: buzzer-on seconds per alarm period.
REQ-003 Parameter RING_OFF_SEC, default 1: buzzer-off seconds per alarm period.
REQ-004 Parameter ALARM_MAX_SEC, default 60: seconds of ringing before auto-hush.
REQ-005 clock  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 enSleep  input  1  level from main sequencer; nap countdown enabled.
REQ-008 enAlarm  input  1  level from main sequencer; alarm phase enabled.
REQ-009 enCancel  input  1  level from main sequencer; abort everything.
REQ-010 napMinutes  input  7  nap length in minutes, sampled on LOAD only.
REQ-011 completeSleep  output  1  level; countdown expired.
REQ-012 remainSec  output  13  seconds remaining in nap.
REQ-013 buzzer  output  1  buzzer drive.
REQ-014 alarmTimeout  output  1  one-cycle pulse on auto-hush.

Function
REQ-015 States: IDLE, LOAD, COUNT, DONE, RING, HUSH; all outputs registered.
REQ-016 enCancel=1 in any state: next state IDLE, overriding every other transition.
REQ-017 IDLE: remainSec=0, completeSleep=0, buzzer=0; enSleep=1 -> LOAD.
REQ-018 LOAD (one cycle): remainSec <= min(napMinutes,99)*60; prescaler cleared; napMinutes=0 -> DONE, else -> COUNT.
REQ-019 COUNT: prescaler counts 0..TICK_DIV-1; on wrap (tick) remainSec decrements by 1.
REQ-020 COUNT: tick while remainSec=1 -> remainSec=0, next state DONE; remainSec never wraps below 0.
REQ-021 COUNT: enSleep=0 (without enCancel) -> IDLE; remainSec cleared.
REQ-022 DONE: completeSleep=1 held until state exit; enAlarm=1 -> RING; enSleep and napMinutes ignored.
REQ-023 RING: entry clears second counter ringSec and prescaler; buzzer=1 on entry cycle.
REQ-024 RING: buzzer=1 while (ringSec mod (RING_ON_SEC+RING_OFF_SEC)) < RING_ON_SEC, else 0; ringSec increments on tick.
REQ-025 RING: tick making ringSec=ALARM_MAX_SEC -> HUSH, buzzer=0, alarmTimeout=1 for that one cycle.
REQ-026 RING: enAlarm=0 -> IDLE, buzzer=0 next cycle.
REQ-027 HUSH: buzzer=0; remains until enCancel=1 or enAlarm=0, then IDLE.
REQ-028 completeSleep=0 in every state except DONE.
REQ-029 Simultaneous tick and enCancel: enCancel wins, no decrement visible.
REQ-030 Illegal state encoding -> IDLE next cycle, outputs as IDLE.

Reset
REQ-031 reset=0 asynchronously forces IDLE, prescaler=0, ringSec=0, remainSec=0, completeSleep=0, buzzer=0, alarmTimeout=0.
REQ-032 Reset release mid-nap does not resume; first active cycle is IDLE.

Structure
REQ-033 Shared package holds state encoding constants, MAX_NAP_MIN=99, and parameter defaults.
REQ-034 One sub-module sec_prescaler: counter with clear input and one-cycle tick output, parameterised by TICK_DIV.

Verification (TICK_DIV=4, RING_ON_SEC=1, RING_OFF_SEC=1, ALARM_MAX_SEC=4)
REQ-035 napMinutes=1, enSleep=1 held -> remainSec=60 after LOAD, completeSleep=1 exactly 240 cycles after COUNT entry.
REQ-036 napMinutes=0, enSleep=1 -> LOAD then DONE, completeSleep=1 two cycles after enSleep.
REQ-037 napMinutes=120 -> remainSec=5940 after LOAD.
REQ-038 DONE then enAlarm=1 -> buzzer pattern 1,1,1,1,0,0,0,0 repeating; alarmTimeout pulse 16 cycles after RING entry, buzzer=0 thereafter.
REQ-039 enCancel=1 during COUNT coincident with tick -> IDLE next cycle, remainSec=0, completeSleep never asserted.
REQ-040 reset=0 asserted mid-RING -> buzzer=0 immediately (no clock edge); after release, state IDLE.

Source files
------------

// File: rtl/nap_timer_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the nap timer controller.
package nap_timer_ctrl_pkg;

  localparam int unsigned TICK_DIV_DEF      = 50_000_000;
  localparam int unsigned RING_ON_SEC_DEF   = 1;
  localparam int unsigned RING_OFF_SEC_DEF  = 1;
  localparam int unsigned ALARM_MAX_SEC_DEF = 60;

  localparam int unsigned MAX_NAP_MIN = 99;
  localparam int unsigned SEC_PER_MIN = 60;
  localparam int unsigned NAP_W       = 7;
  localparam int unsigned REMAIN_W    = 13;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_COUNT = 3'd2,
    ST_DONE  = 3'd3,
    ST_RING  = 3'd4,
    ST_HUSH  = 3'd5
  } state_t;

  // Nap length in seconds, with the minute count clamped to the supported maximum.
  function automatic logic [REMAIN_W-1:0] nap_to_sec(input logic [NAP_W-1:0] mins);
    logic [NAP_W-1:0] clamped;
    clamped = (mins > NAP_W'(MAX_NAP_MIN)) ? NAP_W'(MAX_NAP_MIN) : mins;
    return REMAIN_W'(clamped) * REMAIN_W'(SEC_PER_MIN);
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides the clock down to a one-cycle tick every TICK_DIV cycles while not cleared.
module sec_prescaler #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Free-running divider, held at zero while cleared.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear || (cnt_q == CNT_MAX)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Tick fires in the last cycle of each count period.
  assign tick_c = !clear && (cnt_q == CNT_MAX);

endmodule

// File: rtl/nap_timer_ctrl.sv
// Nap countdown followed by a pulsed alarm with automatic hush after a fixed ringing time.
module nap_timer_ctrl
  import nap_timer_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV      = TICK_DIV_DEF,
  parameter int unsigned RING_ON_SEC   = RING_ON_SEC_DEF,
  parameter int unsigned RING_OFF_SEC  = RING_OFF_SEC_DEF,
  parameter int unsigned ALARM_MAX_SEC = ALARM_MAX_SEC_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enSleep,
  input  logic                enAlarm,
  input  logic                enCancel,
  input  logic [NAP_W-1:0]    napMinutes,
  output logic                completeSleep,
  output logic [REMAIN_W-1:0] remainSec,
  output logic                buzzer,
  output logic                alarmTimeout
);

  localparam int unsigned RING_W      = $clog2(ALARM_MAX_SEC + 1);
  localparam int unsigned RING_PERIOD = RING_ON_SEC + RING_OFF_SEC;

  state_t              state_q, state_d;
  logic [RING_W-1:0]   ring_q, ring_d;
  logic [REMAIN_W-1:0] remain_d;
  logic                complete_d, buzzer_d, timeout_d;
  logic                tick_c, clear_c;

  // The second prescaler only runs while counting down or ringing.
  assign clear_c = !((state_q == ST_COUNT) || (state_q == ST_RING));

  sec_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (clear_c),
    .tick_c(tick_c)
  );

  // State, second counter and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      ring_q        <= '0;
      remainSec     <= '0;
      completeSleep <= 1'b0;
      buzzer        <= 1'b0;
      alarmTimeout  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ring_q        <= ring_d;
      remainSec     <= remain_d;
      completeSleep <= complete_d;
      buzzer        <= buzzer_d;
      alarmTimeout  <= timeout_d;
    end
  end

  // Next state and next output values; cancel overrides every transition.
  always_comb begin
    state_d  = ST_IDLE;
    remain_d = remainSec;
    ring_d   = ring_q;

    case (state_q)
      ST_IDLE: begin
        if (enSleep) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        remain_d = nap_to_sec(napMinutes);
        state_d  = (napMinutes == '0) ? ST_DONE : ST_COUNT;
      end
      ST_COUNT: begin
        if (!enSleep) begin
          state_d = ST_IDLE;
        end else if (tick_c) begin
          if (remainSec <= REMAIN_W'(1)) begin
            remain_d = '0;
            state_d  = ST_DONE;
          end else begin
            remain_d = remainSec - REMAIN_W'(1);
            state_d  = ST_COUNT;
          end
        end else begin
          state_d = ST_COUNT;
        end
      end
      ST_DONE: begin
        if (enAlarm) begin
          ring_d  = '0;
          state_d = ST_RING;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_RING: begin
        if (!enAlarm) begin
          state_d = ST_IDLE;
        end else if (tick_c) begin
          ring_d  = ring_q + RING_W'(1);
          state_d = ((32'(ring_q) + 32'd1) >= ALARM_MAX_SEC) ? ST_HUSH : ST_RING;
        end else begin
          state_d = ST_RING;
        end
      end
      ST_HUSH: begin
        state_d = enAlarm ? ST_HUSH : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enCancel) state_d = ST_IDLE;

    if (state_d == ST_IDLE) begin
      remain_d = '0;
      ring_d   = '0;
    end

    complete_d = (state_d == ST_DONE);
    buzzer_d   = (state_d == ST_RING) && ((32'(ring_d) % RING_PERIOD) < RING_ON_SEC);
    timeout_d  = (state_q == ST_RING) && (state_d == ST_HUSH);
  end

endmodule

// File: tb/tb_nap_timer_ctrl.sv
// Self-checking bench for nap_timer_ctrl with a small arithmetic reference model.
module tb_nap_timer_ctrl;

  localparam int unsigned TD   = 4;
  localparam int unsigned ON   = 1;
  localparam int unsigned OFF  = 1;
  localparam int unsigned AMAX = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enSleep = 1'b0;
  logic        enAlarm = 1'b0;
  logic        enCancel = 1'b0;
  logic [6:0]  napMinutes = 7'd0;
  logic        completeSleep;
  logic [12:0] remainSec;
  logic        buzzer;
  logic        alarmTimeout;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  nap_timer_ctrl #(
    .TICK_DIV     (TD),
    .RING_ON_SEC  (ON),
    .RING_OFF_SEC (OFF),
    .ALARM_MAX_SEC(AMAX)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enSleep      (enSleep),
    .enAlarm      (enAlarm),
    .enCancel     (enCancel),
    .napMinutes   (napMinutes),
    .completeSleep(completeSleep),
    .remainSec    (remainSec),
    .buzzer       (buzzer),
    .alarmTimeout (alarmTimeout)
  );

  // Reference: nap length in seconds from the requested minutes.
  function automatic int unsigned nap_secs(input int unsigned m);
    return ((m > 99) ? 99 : m) * 60;
  endfunction

  // Reference: buzzer level j cycles after entering the ringing phase.
  function automatic logic ring_buzz(input int unsigned j);
    if (j >= AMAX * TD) return 1'b0;
    return ((j / TD) % (ON + OFF)) < ON;
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rem"}, 32'(remainSec), 32'd0);
    chk({tag, "_complete"}, 32'(completeSleep), 32'd0);
    chk({tag, "_buzzer"}, 32'(buzzer), 32'd0);
    chk({tag, "_timeout"}, 32'(alarmTimeout), 32'd0);
  endtask

  // From idle: request a nap, check the load cycle, stop at the first post-load cycle.
  task automatic start_nap(input int unsigned m);
    napMinutes = 7'(m);
    enSleep    = 1'b1;
    cyc();
    chk("load_complete", 32'(completeSleep), 32'd0);
    chk("load_rem", 32'(remainSec), 32'd0);
    cyc();
    napMinutes = 7'($urandom_range(0, 127));
  endtask

  // Countdown: k cycles after load, remaining = total - k/TD; optional abort at cycle abort_k.
  task automatic count_phase(input int unsigned total, input int abort_k, input bit by_cancel,
                             output bit done);
    done = 1'b0;
    for (int k = 0; k < int'(total * TD); k++) begin
      chk("count_rem", 32'(remainSec), 32'(total - int'(k) / TD));
      chk("count_complete", 32'(completeSleep), 32'd0);
      if (k == abort_k) begin
        if (by_cancel) enCancel = 1'b1;
        else enSleep = 1'b0;
        cyc();
        chk("abort_rem", 32'(remainSec), 32'd0);
        chk("abort_complete", 32'(completeSleep), 32'd0);
        enCancel = 1'b0;
        enSleep  = 1'b0;
        cyc();
        chk_idle("abort_idle");
        return;
      end
      cyc();
    end
    chk("done_rem", 32'(remainSec), 32'd0);
    chk("done_complete", 32'(completeSleep), 32'd1);
    done = 1'b1;
  endtask

  // From DONE: hold, start the alarm, follow the buzzer model, then leave at cycle drop_j.
  task automatic alarm_phase(input int hold, input int drop_j, input bit by_cancel);
    enSleep = 1'b0;
    for (int h = 0; h < hold; h++) begin
      cyc();
      chk("hold_complete", 32'(completeSleep), 32'd1);
      chk("hold_buzzer", 32'(buzzer), 32'd0);
    end
    enAlarm = 1'b1;
    for (int j = 0; j <= drop_j; j++) begin
      cyc();
      chk("ring_buzzer", 32'(buzzer), 32'(ring_buzz(j)));
      chk("ring_timeout", 32'(alarmTimeout), 32'(j == int'(AMAX * TD)));
      chk("ring_complete", 32'(completeSleep), 32'd0);
    end
    if (by_cancel) enCancel = 1'b1;
    else enAlarm = 1'b0;
    cyc();
    chk_idle("alarm_exit");
    enCancel = 1'b0;
    enAlarm  = 1'b0;
    cyc();
    chk_idle("alarm_idle");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit done;
    int unsigned m, tot, sel;
    int ab;

    // Reset state while held in reset.
    #2;
    chk_idle("reset");
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    chk_idle("post_reset");

    // One-minute nap held to completion, then full alarm pattern with auto-hush and cancel.
    start_nap(1);
    count_phase(60, -1, 1'b0, done);
    chk("nap1_done", 32'(done), 32'd1);
    alarm_phase(2, 20, 1'b1);

    // Zero-minute nap goes straight to DONE two cycles after the request.
    start_nap(0);
    count_phase(0, -1, 1'b0, done);
    enCancel = 1'b1;
    enSleep  = 1'b0;
    cyc();
    chk_idle("zero_cancel");
    enCancel = 1'b0;

    // Oversized request is clamped; dropping enSleep mid-count returns to idle.
    start_nap(120);
    count_phase(nap_secs(120), 5, 1'b0, done);

    // Cancel in the same cycle as a tick: no decrement visible.
    start_nap(1);
    count_phase(60, int'(TD) - 1, 1'b1, done);

    // Early alarm release just before auto-hush.
    start_nap(0);
    count_phase(0, -1, 1'b0, done);
    alarm_phase(0, int'(AMAX * TD) - 1, 1'b0);

    // Asynchronous reset during ringing.
    start_nap(0);
    count_phase(0, -1, 1'b0, done);
    enSleep = 1'b0;
    enAlarm = 1'b1;
    cyc();
    cyc();
    chk("pre_reset_buzzer", 32'(buzzer), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    chk_idle("async_reset");
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk_idle("after_reset");
    end
    enAlarm = 1'b0;
    cyc();

    // Randomized scenarios against the reference model.
    for (int it = 0; it < 8; it++) begin
      sel = $urandom_range(0, 3);
      if (sel == 3) begin
        m  = $urandom_range(3, 127);
        ab = int'($urandom_range(0, 7));
      end else begin
        m  = sel;
        ab = -1;
        if (m != 0 && $urandom_range(0, 2) == 0) ab = int'($urandom_range(0, m * 60 * TD - 1));
      end
      tot = nap_secs(m);
      start_nap(m);
      count_phase(tot, ab, 1'($urandom_range(0, 1)), done);
      if (done) alarm_phase(int'($urandom_range(0, 3)), int'($urandom_range(0, 22)),
                            1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
